// File: rtl/line_buf_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : line_buf_sched_pkg
// Brief   : Shared types, defaults and helpers for the 3-line buffer scheduler.
// Revision: 1.0
// ============================================================================
package line_buf_sched_pkg;

    localparam int c_DEF_WIDTH  = 512;
    localparam int c_DEF_HEIGHT = 512;
    localparam int c_DEF_DW     = 8;
    localparam int c_NLINES     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buf_sched_raster_cnt.sv
`default_nettype none
// ============================================================================
// Module  : raster_cnt
// Brief   : Column/row raster counters with wrap and last-position flags.
// Revision: 1.0
// ============================================================================
module raster_cnt #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int AW     = 9,
    parameter int RW     = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [AW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_col_last,
    output logic          o_row_last
);

    logic [AW-1:0] r_col;
    logic [RW-1:0] r_row;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (o_col_last) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + AW'(1);
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_col_last = (r_col == AW'(WIDTH - 1));
    assign o_row_last = (r_row == RW'(HEIGHT - 1));

endmodule
`default_nettype wire

// File: rtl/line_buf_sched.sv
`default_nettype none
// ============================================================================
// Module  : line_buf_sched
// Brief   : Rotating 3-line RAM scheduler emitting vertical 3-pixel columns.
// Revision: 1.0
// ============================================================================
module line_buf_sched
    import line_buf_sched_pkg::*;
#(
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int HEIGHT = c_DEF_HEIGHT,
    parameter int AW     = 9,
    parameter int DW     = c_DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pix_valid,
    input  logic [DW-1:0]      pix_in,
    output logic               pix_ready,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_dia,
    output logic [c_NLINES-1:0] ram_ena,
    output logic [c_NLINES-1:0] ram_wea,
    output logic [c_NLINES-1:0] ram_enb,
    input  logic [DW-1:0]      ram_dob0,
    input  logic [DW-1:0]      ram_dob1,
    input  logic [DW-1:0]      ram_dob2,
    output logic               win_valid,
    output logic [DW-1:0]      col_top,
    output logic [DW-1:0]      col_mid,
    output logic [DW-1:0]      col_bot,
    output logic [AW-1:0]      win_col,
    output logic               frame_done
);

    localparam int c_RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t                r_state;
    logic [1:0]            r_wr_sel;
    logic                  r_frame_done;
    logic [AW-1:0]         w_col;
    logic [c_RW-1:0]       w_row;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_accept;
    logic                  w_wrap;
    logic                  w_clr;
    logic                  w_win_acc;
    logic [c_NLINES-1:0]   w_wr_onehot;

    assign pix_ready   = (r_state == ST_FILL) || (r_state == ST_STREAM);
    assign w_accept    = pix_valid && pix_ready;
    assign w_wrap      = w_accept && w_col_last;
    assign w_clr       = (r_state == ST_IDLE) && start;
    assign w_win_acc   = w_accept && (r_state == ST_STREAM);
    assign w_wr_onehot = c_NLINES'(3'b001 << r_wr_sel);

    raster_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .AW     (AW),
        .RW     (c_RW)
    ) u_raster_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_adv      (w_accept),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_col_last (w_col_last),
        .o_row_last (w_row_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_sel     <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_FILL;
                        r_wr_sel <= 2'd0;
                    end
                end
                ST_FILL: begin
                    if (w_wrap) begin
                        r_wr_sel <= mod3_inc(r_wr_sel);
                        if (w_row == c_RW'(1)) r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_wrap) begin
                        r_wr_sel <= mod3_inc(r_wr_sel);
                        if (w_row_last) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign frame_done = r_frame_done;

    // RAM port controls are presented in the accept cycle; the RAMs sample them on the next edge.
    always_comb begin
        ram_addr = '0;
        ram_dia  = '0;
        ram_ena  = '0;
        ram_wea  = '0;
        ram_enb  = '0;
        if (w_accept) begin
            ram_addr = w_col;
            ram_dia  = pix_in;
            ram_ena  = w_wr_onehot;
            ram_wea  = w_wr_onehot;
            ram_enb  = ~w_wr_onehot;
        end
    end

    logic          r_win;
    logic [1:0]    r_sel_d;
    logic [DW-1:0] r_bot;
    logic [AW-1:0] r_col;
    logic [DW-1:0] r_top_hold;
    logic [DW-1:0] r_mid_hold;
    logic [DW-1:0] w_top;
    logic [DW-1:0] w_mid;

    always_comb begin
        w_top = ram_dob1;
        w_mid = ram_dob2;
        case (r_sel_d)
            2'd0:    begin w_top = ram_dob1; w_mid = ram_dob2; end
            2'd1:    begin w_top = ram_dob2; w_mid = ram_dob0; end
            2'd2:    begin w_top = ram_dob0; w_mid = ram_dob1; end
            default: begin w_top = ram_dob1; w_mid = ram_dob2; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win      <= 1'b0;
            r_sel_d    <= 2'd0;
            r_bot      <= '0;
            r_col      <= '0;
            r_top_hold <= '0;
            r_mid_hold <= '0;
        end else begin
            r_win <= w_win_acc;
            if (w_win_acc) begin
                r_sel_d <= r_wr_sel;
                r_bot   <= pix_in;
                r_col   <= w_col;
            end
            if (r_win) begin
                r_top_hold <= w_top;
                r_mid_hold <= w_mid;
            end
        end
    end

    // Read data is live only in the beat after the read; hold copies keep the outputs stable otherwise.
    assign win_valid = r_win;
    assign col_top   = r_win ? w_top : r_top_hold;
    assign col_mid   = r_win ? w_mid : r_mid_hold;
    assign col_bot   = r_bot;
    assign win_col   = r_col;

endmodule
`default_nettype wire
